// File: rtl/dual_write_fifo_reader_if.sv
// dual_write_fifo_reader_if: two write strobes plus the valid/ready read port of the FIFO
interface dual_write_fifo_reader_if #(parameter int WIDTH = 8);
  logic wr0_en, wr1_en, rd_valid, rd_ready;
  logic [WIDTH-1:0] wr0_data, wr1_data, rd_data;
  modport master(output wr0_en, wr0_data, wr1_en, wr1_data, rd_ready, input rd_valid, rd_data);
  modport slave(input wr0_en, wr0_data, wr1_en, wr1_data, rd_ready, output rd_valid, rd_data);
endinterface

// File: rtl/dual_write_fifo_reader.sv
// dual_write_fifo_reader: FIFO absorbing up to two same-cycle writes, drained first-word fall-through
module dual_write_fifo_reader #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter bit COLLAPSE = 1'b1,
  localparam int CW = $clog2(DEPTH+1)
) (
  input  logic clk,
  input  logic rst_n,
  dual_write_fifo_reader_if.slave bus,
  output logic [CW-1:0] count,
  output logic full,
  output logic [15:0] drop_cnt,
  output logic overflow
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic pop, both, coll;
  logic [CW-1:0] free;
  logic [1:0] n_cand, n_store, drops;
  logic [WIDTH-1:0] c0;
  logic [16:0] dsum;
  assign bus.rd_valid = count != '0;
  assign bus.rd_data = mem[rptr];
  assign full = count == CW'(DEPTH);
  always_comb begin
    both = bus.wr0_en && bus.wr1_en;
    coll = both && COLLAPSE;
    pop = bus.rd_valid && bus.rd_ready;
    free = CW'(DEPTH) - count + CW'(pop);
    n_cand = both ? (COLLAPSE ? 2'd1 : 2'd2) : {1'b0, bus.wr0_en | bus.wr1_en};
    n_store = (free >= CW'(n_cand)) ? n_cand : free[1:0];
    c0 = (bus.wr0_en && !coll) ? bus.wr0_data : bus.wr1_data;
    drops = n_cand - n_store + {1'b0, coll};
    dsum = {1'b0, drop_cnt} + 17'(drops);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      wptr <= wptr + AW'(n_store);
      rptr <= rptr + AW'(pop);
      count <= count + CW'(n_store) - CW'(pop);
      drop_cnt <= dsum[16] ? 16'hFFFF : dsum[15:0];
      if (n_store != n_cand) overflow <= 1'b1;
    end
  // storage is not reset; only the pointers define what is valid
  always_ff @(posedge clk) begin
    if (rst_n && n_store != 2'd0) mem[wptr] <= c0;
    if (rst_n && n_store == 2'd2) mem[wptr + AW'(1)] <= bus.wr1_data;
  end
endmodule

// File: tb/tb_dual_write_fifo_reader.sv
// tb_dual_write_fifo_reader: scoreboard bench driving a collapsing and a non-collapsing instance
module tb_dual_write_fifo_reader;
  logic clk, rst_n;
  logic [2:0] cnt1, cnt0;
  logic full1, full0, ovf1, ovf0;
  logic [15:0] drop1, drop0;
  int checks = 0, errors = 0;
  logic [7:0] q1[$], q0[$];
  dual_write_fifo_reader_if #(.WIDTH(8)) b1();
  dual_write_fifo_reader_if #(.WIDTH(8)) b0();
  dual_write_fifo_reader #(.WIDTH(8), .DEPTH(4), .COLLAPSE(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(b1.slave), .count(cnt1), .full(full1), .drop_cnt(drop1), .overflow(ovf1));
  dual_write_fifo_reader #(.WIDTH(8), .DEPTH(4), .COLLAPSE(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(b0.slave), .count(cnt0), .full(full0), .drop_cnt(drop0), .overflow(ovf0));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk)
    if (rst_n && b1.rd_valid && b1.rd_ready) begin
      if (q1.size() == 0) chk("rd1_unexpected", 1, 0);
      else chk("rd1_data", b1.rd_data, q1.pop_front());
    end
  always @(negedge clk)
    if (rst_n && b0.rd_valid && b0.rd_ready) begin
      if (q0.size() == 0) chk("rd0_unexpected", 1, 0);
      else chk("rd0_data", b0.rd_data, q0.pop_front());
    end
  task automatic wr0(input logic e0, input logic [7:0] d0, input logic e1, input logic [7:0] d1);
    b0.wr0_en = e0; b0.wr0_data = d0; b0.wr1_en = e1; b0.wr1_data = d1;
  endtask
  initial begin
    rst_n = 1'b0;
    b1.wr0_en = 0; b1.wr1_en = 0; b1.wr0_data = 0; b1.wr1_data = 0; b1.rd_ready = 0;
    b0.wr0_en = 0; b0.wr1_en = 0; b0.wr0_data = 0; b0.wr1_data = 0; b0.rd_ready = 0;
    #1;
    chk("rst_count1", cnt1, 0); chk("rst_valid1", b1.rd_valid, 0); chk("rst_full1", full1, 0);
    chk("rst_drop1", drop1, 0); chk("rst_ovf1", ovf1, 0);
    chk("rst_count0", cnt0, 0); chk("rst_valid0", b0.rd_valid, 0); chk("rst_ovf0", ovf0, 0);
    cyc(); cyc();
    rst_n = 1'b1;
    // collapse: only the later write survives
    b1.wr0_en = 1; b1.wr0_data = 8'h10; b1.wr1_en = 1; b1.wr1_data = 8'h20; q1.push_back(8'h20);
    cyc();
    b1.wr0_en = 0; b1.wr1_en = 0;
    chk("t1_count", cnt1, 1); chk("t1_valid", b1.rd_valid, 1); chk("t1_data", b1.rd_data, 8'h20);
    chk("t1_drop", drop1, 1); chk("t1_ovf", ovf1, 0);
    b1.rd_ready = 1; cyc(); b1.rd_ready = 0;
    chk("t1_count_after", cnt1, 0);
    // no collapse: both kept in order
    wr0(1, 8'h10, 1, 8'h20); q0.push_back(8'h10); q0.push_back(8'h20);
    cyc(); wr0(0, 0, 0, 0);
    chk("t2_count", cnt0, 2);
    b0.rd_ready = 1; cyc(); cyc(); b0.rd_ready = 0;
    chk("t2_valid", b0.rd_valid, 0); chk("t2_count_after", cnt0, 0); chk("t2_drop", drop0, 0);
    // fill to 3 across the pointer wrap, then one space drop
    for (int i = 1; i <= 3; i++) begin
      wr0(1, 8'(i), 0, 0); q0.push_back(8'(i)); cyc();
    end
    wr0(0, 0, 0, 0);
    chk("t3_count3", cnt0, 3);
    wr0(1, 8'h31, 1, 8'h32); q0.push_back(8'h31);
    cyc(); wr0(0, 0, 0, 0);
    chk("t3_count", cnt0, 4); chk("t3_full", full0, 1); chk("t3_drop", drop0, 1); chk("t3_ovf", ovf0, 1);
    // full with simultaneous pop and write
    b0.rd_ready = 1; wr0(1, 8'h55, 0, 0); q0.push_back(8'h55);
    cyc(); wr0(0, 0, 0, 0);
    chk("t4_count", cnt0, 4); chk("t4_drop", drop0, 1);
    repeat (4) cyc();
    b0.rd_ready = 0;
    chk("t4_count_after", cnt0, 0); chk("t4_q_left", q0.size(), 0);
    // asynchronous reset mid-operation
    for (int i = 0; i < 3; i++) begin
      wr0(1, 8'h41 + 8'(i), 0, 0); q0.push_back(8'h41 + 8'(i)); cyc();
    end
    wr0(0, 0, 0, 0);
    chk("t5_count3", cnt0, 3);
    #4 rst_n = 1'b0;
    #1;
    chk("t5_count", cnt0, 0); chk("t5_valid", b0.rd_valid, 0);
    chk("t5_drop", drop0, 0); chk("t5_ovf", ovf0, 0); chk("t5_drop1", drop1, 0);
    q0.delete(); q1.delete();
    cyc(); rst_n = 1'b1;
    wr0(1, 8'hA5, 0, 0); q0.push_back(8'hA5);
    cyc(); wr0(0, 0, 0, 0);
    chk("t5_data", b0.rd_data, 8'hA5); chk("t5_count1", cnt0, 1); chk("t5_valid1", b0.rd_valid, 1);
    b0.rd_ready = 1; cyc(); b0.rd_ready = 0;
    // drop counter saturation with steady draining
    b1.rd_ready = 1; b1.wr0_en = 1; b1.wr1_en = 1;
    for (int i = 0; i < 65540; i++) begin
      b1.wr0_data = ~8'(i); b1.wr1_data = 8'(i); q1.push_back(8'(i));
      cyc();
      if (i == 65533) chk("t6_drop_fffe", drop1, 16'hFFFE);
    end
    b1.wr0_en = 0; b1.wr1_en = 0;
    cyc(); b1.rd_ready = 0;
    chk("t6_drop", drop1, 16'hFFFF); chk("t6_ovf", ovf1, 0); chk("t6_count", cnt1, 0);
    chk("q1_left", q1.size(), 0); chk("q0_left", q0.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dual_write_fifo_reader.md
Name: dual_write_fifo_reader

Overview:
- Buffers up to two same-cycle register writes (ports wr0, wr1, in program order) and drains them to a consumer through a valid/ready read port.
- Receiving end of the same-cycle multiple-write pattern. COLLAPSE selects the storage policy:
  - COLLAPSE=1: last write wins, as with two back-to-back assignments to one variable.
  - COLLAPSE=0: both writes are kept, in order.
- Placed between a register-update producer and a sampling consumer.

Parameters:
- WIDTH, 8: data width in bits.
- DEPTH, 4: entry count. Power of 2, ≥4.
- COLLAPSE, 1: 1 = when both ports write in one cycle, store only wr1. 0 = store wr0 then wr1.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- wr0_en  in  1  first (earlier) write strobe.
- wr0_data  in  WIDTH  first write data.
- wr1_en  in  1  second (later) write strobe.
- wr1_data  in  WIDTH  second write data.
- rd_valid  out  1  head entry available.
- rd_ready  in  1  consumer accepts head entry.
- rd_data  out  WIDTH  head entry (first-word fall-through from memory at rptr).
- count  out  $clog2(DEPTH+1)  current occupancy.
- full  out  1  count==DEPTH.
- drop_cnt  out  16  discarded writes; saturates at 16'hFFFF.
- overflow  out  1  sticky; set when any write is dropped for lack of space.

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect immediately):
  - wptr, rptr, count, drop_cnt, overflow all = 0; rd_valid=0; full=0.
  - Memory contents are not reset; rd_data is don't-care while rd_valid=0.
- Derived signals:
  - rd_valid = (count!=0), combinational from registered count.
  - pop = rd_valid && rd_ready.
  - free = DEPTH - count + pop. A same-cycle pop frees a slot for a same-cycle write.
- Write candidate list per cycle, in order:
  - COLLAPSE=1, both enables: candidate {wr1_data}; wr0 is a collapse drop.
  - COLLAPSE=0, both enables: candidates {wr0_data, wr1_data}.
  - Single enable: that port's data.
  - Enables=0: no candidates.
- Storage:
  - Store the first min(free, #candidates) candidates at wptr, wptr+1 (mod DEPTH).
  - Remaining candidates are space drops.
  - Pointers wrap modulo DEPTH.
- Next count = count + stored - pop. It never exceeds DEPTH and never goes below 0.
- Latency: data written at edge N is visible on rd_data with rd_valid=1 after edge N (one cycle write-to-read). No combinational write-to-read bypass when empty.
- Read on an empty FIFO (rd_ready=1, count=0): no state change.
- Pop advances rptr at the edge; rd_data then shows the next entry.
- drop_cnt:
  - Increments by the number of dropped candidates that cycle (collapse drops plus space drops, 0–2).
  - Saturates at FFFF and does not wrap.
- overflow:
  - Set at the edge on any space drop.
  - Collapse drops do not set it.
  - Cleared only by reset.
- All outputs are registered or derived from registers only. No combinational path from wr*_en to rd_valid.
- Reset asserted mid-burst discards all contents. The first write after deassertion lands in entry 0.

Test Plan:
- COLLAPSE=1, DEPTH=4, empty. One cycle wr0=10, wr1=20 → after edge: count=1, rd_valid=1, rd_data=20, drop_cnt=1, overflow=0.
- COLLAPSE=0. One cycle wr0=10, wr1=20, rd_ready=0 → count=2. Then rd_ready=1 for two cycles → rd_data 10 then 20, rd_valid=0, count=0, drop_cnt=0.
- COLLAPSE=0. Fill to count=3, then wr0=8'h31, wr1=8'h32, rd_ready=0 → count=4, full=1, 8'h31 stored, 8'h32 dropped, drop_cnt=1, overflow=1. Drain order is preserved through pointer wrap.
- Full (count=4), rd_ready=1, wr0=8'h55 only → pop and write in the same cycle: count stays 4, no drop, 8'h55 is read last after draining.
- Mid-operation, count=3: drop rst_n to 0 halfway between edges → count, rd_valid, drop_cnt, overflow = 0 before the next posedge. After release, write 8'hA5 → rd_data=8'hA5, count=1.
- Saturation: force 65540 collapse drops (COLLAPSE=1, both enables, with reads draining) → drop_cnt=16'hFFFF held, overflow=0.
